// File: rtl/equiv_stim_sequencer_if.sv
// Bundle between the campaign driver, the equivalence sequencer and the
// golden/netlist DUT pair: run request, stimulus, both y buses and results.
interface equiv_stim_sequencer_if #(
  parameter int STIM_W = 62,
  parameter int Y_W    = 192
);
  logic              start;
  logic [STIM_W-1:0] stim;
  logic [Y_W-1:0]    y_gold;
  logic [Y_W-1:0]    y_dut;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       mism_cnt;
  logic [15:0]       first_fail_idx;
  logic              first_fail_vld;
  logic [31:0]       sig;

  modport master (
    input  start, y_gold, y_dut,
    output stim, busy, done, pass,
    output mism_cnt, first_fail_idx,
    output first_fail_vld, sig
  );

  modport slave (
    output start, y_gold, y_dut,
    input  stim, busy, done, pass,
    input  mism_cnt, first_fail_idx,
    input  first_fail_vld, sig
  );
endinterface

// File: rtl/equiv_stim_sequencer.sv
// LFSR stimulus sequencer and y_gold/y_dut lockstep comparator.
// Define EQV_MISR_EN to build the 32-bit MISR signature of y_dut on sig.
module equiv_stim_sequencer #(
  parameter int          STIM_W   = 62,
  parameter int          Y_W      = 192,
  parameter int unsigned NUM_VECT = 1024,
  parameter int unsigned LAT      = 2,
  parameter logic [63:0] SEED     = 64'hACE1_0000_0000_0001
) (
  input logic                   clk,
  input logic                   rst_n,
  equiv_stim_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned NV = (NUM_VECT == 0) ? 1 : NUM_VECT;
  localparam logic [63:0] SEED0 = (SEED == 64'h0) ? 64'h1 : SEED;

  state_t          state;
  logic [63:0]     lfsr;
  logic [31:0]     vidx;
  logic [LAT-1:0]  tag_vld;
  logic [15:0]     tag_idx [LAT];
  logic            fb;
  logic            cmp;
  logic            miss;

  assign fb   = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
  assign cmp  = tag_vld[LAT-1];
  assign miss = cmp && (bus.y_gold != bus.y_dut);

`ifdef EQV_MISR_EN
  function automatic logic [31:0] fold(input logic [Y_W-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < Y_W / 32; i++)
      f ^= y[i*32 +: 32];
    return f;
  endfunction
`else
  assign bus.sig = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      bus.stim           <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.mism_cnt       <= '0;
      bus.first_fail_idx <= '0;
      bus.first_fail_vld <= 1'b0;
      lfsr               <= SEED0;
      vidx               <= '0;
      tag_vld            <= '0;
      for (int i = 0; i < int'(LAT); i++)
        tag_idx[i] <= '0;
`ifdef EQV_MISR_EN
      bus.sig            <= '0;
`endif
    end else begin
      bus.done   <= 1'b0;
      tag_vld[0] <= (state == RUN);
      tag_idx[0] <= vidx[15:0];
      for (int i = 1; i < int'(LAT); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end

      if (miss) begin
        if (bus.mism_cnt != 16'hFFFF)
          bus.mism_cnt <= bus.mism_cnt + 16'd1;
        if (!bus.first_fail_vld) begin
          bus.first_fail_vld <= 1'b1;
          bus.first_fail_idx <= tag_idx[LAT-1];
        end
      end

`ifdef EQV_MISR_EN
      if (cmp)
        bus.sig <= {bus.sig[30:0], 1'b0}
                 ^ (bus.sig[31] ? 32'h04C1_1DB7 : 32'h0)
                 ^ fold(bus.y_dut);
`endif

      // run-clearing below must win over the compare updates above
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state              <= RUN;
            bus.busy           <= 1'b1;
            bus.pass           <= 1'b0;
            bus.mism_cnt       <= '0;
            bus.first_fail_idx <= '0;
            bus.first_fail_vld <= 1'b0;
            lfsr               <= SEED0;
            vidx               <= '0;
`ifdef EQV_MISR_EN
            bus.sig            <= '0;
`endif
          end
        end
        RUN: begin
          bus.stim <= lfsr[STIM_W-1:0];
          lfsr     <= {lfsr[62:0], fb};
          vidx     <= vidx + 32'd1;
          if (vidx == NV - 1)
            state <= DRAIN;
        end
        DRAIN: begin
          if (tag_vld == '0) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.mism_cnt == 16'd0);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_stim_sequencer.sv
// Bench for equiv_stim_sequencer: short runs with injected mismatches,
// mid-run reset, reruns, and a saturating long run on a second instance.
module tb_equiv_stim_sequencer;

  localparam int N   = 16;
  localparam int LAT = 2;
  localparam int NB  = 70000;
  localparam logic [63:0] SEED = 64'hACE1_0000_0000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  equiv_stim_sequencer_if #(.STIM_W(62), .Y_W(192)) bus ();
  equiv_stim_sequencer_if #(.STIM_W(62), .Y_W(192)) big ();

  equiv_stim_sequencer #(
    .STIM_W(62), .Y_W(192), .NUM_VECT(N), .LAT(LAT), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  equiv_stim_sequencer #(
    .STIM_W(62), .Y_W(192), .NUM_VECT(NB), .LAT(LAT), .SEED(SEED)
  ) dut_big (
    .clk(clk), .rst_n(rst_n), .bus(big.master)
  );

  // DUT pair model: y follows stim through one register
  logic [61:0] ys  = '0;
  logic [61:0] ysb = '0;
  always @(posedge clk) begin
    ys  <= bus.stim;
    ysb <= big.stim;
  end

  logic [61:0] bad_stim [4];
  int          bad_n = 0;
  logic        hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i < bad_n && ys == bad_stim[i]) hit = 1'b1;
  end

  assign bus.y_gold = {ys, ys, ys, 6'd0};
  assign bus.y_dut  = bus.y_gold ^ {191'd0, hit};
  assign big.y_gold = {ysb, ysb, ysb, 6'd0};
  assign big.y_dut  = ~big.y_gold;

  logic [61:0] exp_stim [N];
  int n_chk  = 0;
  int n_fail = 0;
`ifdef EQV_MISR_EN
  logic [31:0] sig_a;
`endif

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; start is sampled at the next posedge
  task automatic do_run(input int ign_at, input int ecnt, input int efirst);
    int idx;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_start", bus.busy, 1);
    chk("done_start", bus.done, 0);
    for (int c = 1; c <= N + LAT + 1; c++) begin
      bus.start = (c == ign_at);
      @(negedge clk);
      idx = (c <= N) ? c - 1 : N - 1;
      chk("stim", bus.stim, exp_stim[idx]);
      chk("busy", bus.busy, c <= N + LAT);
      chk("done", bus.done, c == N + LAT + 1);
    end
    bus.start = 1'b0;
    chk("pass", bus.pass, ecnt == 0);
    chk("mism_cnt", bus.mism_cnt, ecnt);
    chk("ff_vld", bus.first_fail_vld, ecnt != 0);
    chk("ff_idx", bus.first_fail_idx, efirst);
  endtask

  initial begin
    logic [63:0] s;
    int picked [4];
    int nb, mn, ign, k, cyc;
    bit dup;

    s = SEED;
    for (int i = 0; i < N; i++) begin
      exp_stim[i] = s[61:0];
      s = lfsr_next(s);
    end

    bus.start = 1'b0;
    big.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stim", bus.stim, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_mism", bus.mism_cnt, 0);
    chk("rst_ffv", bus.first_fail_vld, 0);
    chk("rst_ffi", bus.first_fail_idx, 0);
    chk("rst_sig", bus.sig, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    bad_n = 0;
    do_run(0, 0, 0);
`ifdef EQV_MISR_EN
    sig_a = bus.sig;
    chk("sig_nonzero", sig_a != 0, 1);
`else
    chk("sig_tied", bus.sig, 0);
`endif

    // restart straight from the done cycle
    bad_n = 1;
    bad_stim[0] = exp_stim[5];
    do_run(0, 1, 5);
`ifdef EQV_MISR_EN
    chk("sig_differs", bus.sig != sig_a, 1);
`endif

    for (int r = 0; r < 4; r++) begin
      nb = $urandom_range(1, 4);
      mn = N;
      for (int i = 0; i < nb; i++) begin
        do begin
          k = $urandom_range(0, N - 1);
          dup = 1'b0;
          for (int j = 0; j < i; j++)
            if (picked[j] == k) dup = 1'b1;
        end while (dup);
        picked[i]   = k;
        bad_stim[i] = exp_stim[k];
        if (k < mn) mn = k;
      end
      bad_n = nb;
      ign = $urandom_range(1, N + LAT);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(ign, nb, mn);
    end

    bad_n = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_stim", bus.stim, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_mism", bus.mism_cnt, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk("mrst_nodone", bus.done, 0);
    end
    chk("mrst_idle", bus.busy, 0);

    do_run(0, 0, 0);
`ifdef EQV_MISR_EN
    chk("sig_repeat", bus.sig, sig_a);
`endif

    big.start = 1'b1;
    @(negedge clk);
    big.start = 1'b0;
    cyc = 0;
    while (!big.done && cyc < NB + LAT + 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("big_latency", cyc, NB + LAT + 1);
    chk("big_mism_sat", big.mism_cnt, 16'hFFFF);
    chk("big_ff_idx", big.first_fail_idx, 0);
    chk("big_ff_vld", big.first_fail_vld, 1);
    chk("big_pass", big.pass, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
